// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the wheel pulse meter: state encodings and parameter defaults.
package pulse_meter_pkg;

    localparam int unsigned CNT_W_DEF       = 20;
    localparam int unsigned WAIT_W_DEF      = 16;
    localparam int unsigned CLK_HZ_DEF      = 50000000;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2
    } drive_stat_e;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-cycle
// falling-edge strobe.
module edge_sync
    import pulse_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Reset to 1 so that leaving reset with the input high never fakes an edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_meter.sv
// Trip meter: counts wheel pulses while driving and whole seconds spent waiting,
// with a key that toggles between DRIVE and WAIT.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned WAIT_W      = WAIT_W_DEF,
    parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pulse_port,
    input  logic              stat_change,
    input  logic              trip_clr,
    output logic [CNT_W-1:0]  pulse_num,
    output logic [WAIT_W-1:0] wait_sec,
    output logic [1:0]        drive_stat,
    output logic              pulse_ovf
);

    localparam int unsigned       PRESC_W   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    logic pulse_fall;
    logic key_evt;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pulse_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (pulse_port),
        .fall      (pulse_fall)
    );

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (stat_change),
        .fall      (key_evt)
    );

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   pulse_num_q;
    logic [WAIT_W-1:0]  wait_sec_q;
    logic [PRESC_W-1:0] presc_q;
    logic               pulse_ovf_q;

    logic new_trip;
    logic enter_wait;
    logic count_en;
    logic in_wait;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (key_evt) state_d = ST_DRIVE;
            ST_WAIT:  if (key_evt) state_d = ST_DRIVE;
            ST_DRIVE: if (key_evt) state_d = ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
        if (trip_clr) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath controls decoded from the registered state; trip_clr masks transitions.
    always_comb begin
        new_trip   = (state_q == ST_IDLE) && key_evt && !trip_clr;
        enter_wait = (state_q == ST_DRIVE) && key_evt && !trip_clr;
        count_en   = (state_q == ST_DRIVE) && pulse_fall;
        in_wait    = (state_q == ST_WAIT);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pulse_num_q <= '0;
            wait_sec_q  <= '0;
            presc_q     <= '0;
            pulse_ovf_q <= 1'b0;
        end else if (trip_clr || new_trip) begin
            pulse_num_q <= '0;
            wait_sec_q  <= '0;
            presc_q     <= '0;
            pulse_ovf_q <= 1'b0;
        end else begin
            if (count_en) begin
                if (&pulse_num_q) begin
                    pulse_ovf_q <= 1'b1;
                end else begin
                    pulse_num_q <= pulse_num_q + 1'b1;
                end
            end
            if (enter_wait) begin
                presc_q <= '0;
            end else if (in_wait) begin
                if (presc_q == PRESC_MAX) begin
                    presc_q <= '0;
                    if (!(&wait_sec_q)) begin
                        wait_sec_q <= wait_sec_q + 1'b1;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    assign pulse_num  = pulse_num_q;
    assign wait_sec   = wait_sec_q;
    assign drive_stat = state_q;
    assign pulse_ovf  = pulse_ovf_q;

endmodule
